regfile_mp: RTL and testbench

//  Parametrised multi-port register file with write-through bypass, dual write ports,
//  per-register busy scoreboard and a sequential clear engine.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_mp.sv | 111 +++++++++++
 tb/tb_regfile_mp.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_NRD   = 3;
endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bus of the register file; master = datapath, slave = regfile.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD
);
    localparam int AW = $clog2(DEPTH);

    logic                      clr_req;
    logic                      ready;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][WIDTH-1:0] rd_data;
    logic [NRD-1:0]            rd_busy;
    logic [1:0]                wr_en;
    logic [1:0][AW-1:0]        wr_addr;
    logic [1:0][WIDTH-1:0]     wr_data;
    logic                      iss_en;
    logic [AW-1:0]             iss_addr;

    modport master (
        output clr_req, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  ready, rd_data, rd_busy
    );

    modport slave (
        input  clr_req, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output ready, rd_data, rd_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush zeroes all.
module regfile_scoreboard #(
    parameter int DEPTH = 16,
    parameter int NRD   = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   set_en,
    input  logic [AW-1:0]          set_addr,
    input  logic [1:0]             clr_en,
    input  logic [1:0][AW-1:0]     clr_addr,
    input  logic [NRD-1:0][AW-1:0] lk_addr,
    output logic [NRD-1:0]         lk_busy
);
    logic [DEPTH-1:0] busy_q, busy_d;

    // Set is applied after the clears so a same-cycle reissue stays busy.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (clr_en[p]) busy_d[clr_addr[p]] = 1'b0;
            end
            if (set_en) busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        lk_busy = '0;
        for (int k = 0; k < NRD; k++) lk_busy[k] = busy_q[lk_addr[k]];
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports with write-through
// bypass, two write ports, busy scoreboard and a one-register-per-cycle clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NRD     = DEF_NRD,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    state_e                      state_q, state_d;
    logic [AW-1:0]               cnt_q, cnt_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic                        run;
    logic [1:0]                  we;
    logic                        set_en;
    logic [NRD-1:0]              sb_busy;
    logic [NRD-1:0][WIDTH-1:0]   rd_data;
    logic [NRD-1:0]              rd_busy;

    assign run = (state_q == RUN);

    // Effective write enables: nothing commits while clearing or on a clear request.
    always_comb begin
        we = '0;
        for (int p = 0; p < 2; p++) begin
            we[p] = bus.wr_en[p] && run && !bus.clr_req &&
                    !(ZERO_R0 && bus.wr_addr[p] == '0);
        end
    end

    assign set_en = bus.iss_en && run && !bus.clr_req &&
                    !(ZERO_R0 && bus.iss_addr == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) state_d = RUN;
        end else if (bus.clr_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (!run) mem_d[cnt_q] = '0;
        for (int p = 0; p < 2; p++) begin
            if (we[p]) mem_d[bus.wr_addr[p]] = bus.wr_data[p];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (!run || bus.clr_req),
        .set_en   (set_en),
        .set_addr (bus.iss_addr),
        .clr_en   (we),
        .clr_addr (bus.wr_addr),
        .lk_addr  (bus.rd_addr),
        .lk_busy  (sb_busy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_data[k] = mem_q[bus.rd_addr[k]];
            for (int p = 0; p < 2; p++) begin
                if (we[p] && bus.wr_addr[p] == bus.rd_addr[k]) rd_data[k] = bus.wr_data[p];
            end
            rd_busy[k] = sb_busy[k] && run;
            if (!run || (ZERO_R0 && bus.rd_addr[k] == '0)) begin
                rd_data[k] = '0;
                rd_busy[k] = 1'b0;
            end
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.rd_busy = rd_busy;
    assign bus.ready   = run;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed table, corner sequences and random traffic
// against an array-based model; instance 1 has register 0 hardwired to zero.
module tb_regfile_mp;
    logic clk;
    logic t_rst, t_clr, t_iss;
    logic [2:0][3:0]  t_ra;
    logic [1:0]       t_wen;
    logic [1:0][3:0]  t_wa;
    logic [1:0][15:0] t_wd;
    logic [3:0]       t_ia;

    regfile_mp_if #(.WIDTH(16), .DEPTH(16), .NRD(3)) bus0 ();
    regfile_mp_if #(.WIDTH(16), .DEPTH(16), .NRD(3)) bus1 ();

    assign bus0.clr_req = t_clr;  assign bus1.clr_req = t_clr;
    assign bus0.rd_addr = t_ra;   assign bus1.rd_addr = t_ra;
    assign bus0.wr_en   = t_wen;  assign bus1.wr_en   = t_wen;
    assign bus0.wr_addr = t_wa;   assign bus1.wr_addr = t_wa;
    assign bus0.wr_data = t_wd;   assign bus1.wr_data = t_wd;
    assign bus0.iss_en  = t_iss;  assign bus1.iss_en  = t_iss;
    assign bus0.iss_addr = t_ia;  assign bus1.iss_addr = t_ia;

    regfile_mp #(.WIDTH(16), .DEPTH(16), .NRD(3), .ZERO_R0(1'b0))
        u_dut0 (.clk(clk), .rst(t_rst), .bus(bus0));
    regfile_mp #(.WIDTH(16), .DEPTH(16), .NRD(3), .ZERO_R0(1'b1))
        u_dut1 (.clk(clk), .rst(t_rst), .bus(bus1));

    logic [1:0]       act_ready;
    logic [2:0][15:0] act_rd [2];
    logic [2:0]       act_busy [2];
    assign act_ready   = {bus1.ready, bus0.ready};
    assign act_rd[0]   = bus0.rd_data;
    assign act_rd[1]   = bus1.rd_data;
    assign act_busy[0] = bus0.rd_busy;
    assign act_busy[1] = bus1.rd_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: register contents, busy flags, cycles left in clear.
    logic [15:0] m_mem [2][16];
    bit          m_busy [2][16];
    int          m_left [2];
    bit          m_valid = 1'b0;

    task automatic chk(input string nm, input int i, input int k,
                       input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d port=%0d got=%h want=%h", nm, i, k, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int i, input int k);
        logic [3:0] a;
        a = t_ra[k];
        if (m_left[i] != 0) return 16'h0;
        if (i == 1 && a == 4'd0) return 16'h0;
        if (!t_clr && t_wen[1] && t_wa[1] == a) return t_wd[1];
        if (!t_clr && t_wen[0] && t_wa[0] == a) return t_wd[0];
        return m_mem[i][a];
    endfunction

    function automatic logic [15:0] exp_busy(input int i, input int k);
        if (m_left[i] != 0 || (i == 1 && t_ra[k] == 4'd0)) return 16'h0;
        return 16'(m_busy[i][t_ra[k]]);
    endfunction

    task automatic model_wipe(input int i);
        m_left[i] = 16;
        for (int r = 0; r < 16; r++) begin
            m_mem[i][r]  = 16'h0;
            m_busy[i][r] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (t_rst) model_wipe(i);
            else if (m_left[i] > 0) m_left[i]--;
            else if (t_clr) model_wipe(i);
            else begin
                for (int p = 0; p < 2; p++)
                    if (t_wen[p] && !(i == 1 && t_wa[p] == 4'd0)) m_mem[i][t_wa[p]] = t_wd[p];
                for (int p = 0; p < 2; p++)
                    if (t_wen[p]) m_busy[i][t_wa[p]] = 1'b0;
                if (t_iss && !(i == 1 && t_ia == 4'd0)) m_busy[i][t_ia] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        if (!m_valid) return;
        for (int i = 0; i < 2; i++) begin
            chk("model_ready", i, 0, 16'(act_ready[i]), 16'(m_left[i] == 0));
            for (int k = 0; k < 3; k++) begin
                chk("model_rd_data", i, k, act_rd[i][k], exp_rd(i, k));
                chk("model_rd_busy", i, k, 16'(act_busy[i][k]), exp_busy(i, k));
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        t_rst = 1'b0; t_clr = 1'b0; t_iss = 1'b0; t_ia = 4'd0;
        t_wen = 2'b00; t_wa = '0; t_wd = '0;
    endtask

    task automatic sweep_zero(input string nm);
        for (int g = 0; g < 16; g += 3) begin
            idle();
            for (int k = 0; k < 3; k++) t_ra[k] = 4'((g + k) % 16);
            sample();
            for (int k = 0; k < 3; k++) begin
                chk(nm, 0, k, act_rd[0][k], 16'h0);
                chk(nm, 0, k, 16'(act_busy[0][k]), 16'h0);
            end
            advance();
        end
    endtask

    task automatic expect_clear_window(input string nm);
        for (int c = 0; c < 16; c++) begin
            sample();
            chk(nm, 0, c, 16'(act_ready[0]), 16'h0);
            chk(nm, 1, c, 16'(act_ready[1]), 16'h0);
            advance();
        end
        sample();
        chk({nm, "_up"}, 0, 0, 16'(act_ready[0]), 16'h1);
        chk({nm, "_up"}, 1, 0, 16'(act_ready[1]), 16'h1);
        advance();
    endtask

    typedef struct {
        logic [1:0]  wen;
        logic [3:0]  wa0;
        logic [15:0] wd0;
        logic [3:0]  wa1;
        logic [15:0] wd1;
        logic        iss;
        logic [3:0]  ia;
        logic [3:0]  ra0, ra1, ra2;
        logic [15:0] e0, e1, e2;
        logic [2:0]  eb;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{2'b01, 4'd0, 16'hABCD, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 16'hABCD, 16'h0000, 16'h0000, 3'b000};
        tbl[1]  = '{2'b01, 4'd1, 16'h29CA, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 16'hABCD, 16'h29CA, 16'h0000, 3'b000};
        tbl[2]  = '{2'b01, 4'd2, 16'hC11F, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 16'hABCD, 16'h29CA, 16'hC11F, 3'b000};
        tbl[3]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 16'hABCD, 16'h29CA, 16'hC11F, 3'b000};
        tbl[4]  = '{2'b11, 4'd5, 16'h1111, 4'd5, 16'h2222, 1'b0, 4'd0, 4'd5, 4'd5, 4'd0, 16'h2222, 16'h2222, 16'hABCD, 3'b000};
        tbl[5]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd0, 4'd0, 16'h2222, 16'hABCD, 16'hABCD, 3'b000};
        tbl[6]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd3, 4'd5, 4'd0, 16'h0000, 16'h2222, 16'hABCD, 3'b000};
        tbl[7]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3, 4'd3, 16'h0000, 16'h0000, 16'h0000, 3'b111};
        tbl[8]  = '{2'b10, 4'd0, 16'h0000, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd3, 4'd0, 4'd1, 16'hBEEF, 16'hABCD, 16'h29CA, 3'b001};
        tbl[9]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3, 4'd4, 16'hBEEF, 16'hBEEF, 16'h0000, 3'b000};
        tbl[10] = '{2'b01, 4'd4, 16'h4444, 4'd0, 16'h0000, 1'b1, 4'd4, 4'd4, 4'd3, 4'd3, 16'h4444, 16'hBEEF, 16'hBEEF, 3'b000};
        tbl[11] = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd4, 4'd3, 16'h4444, 16'h4444, 16'hBEEF, 3'b011};
        tbl[12] = '{2'b01, 4'd4, 16'h5555, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd1, 4'd2, 16'h5555, 16'h29CA, 16'hC11F, 3'b001};
        tbl[13] = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd0, 4'd5, 16'h5555, 16'hABCD, 16'h2222, 3'b000};

        idle();
        t_ra = '0;
        t_rst = 1'b1;
        advance();
        m_valid = 1'b1;
        t_rst = 1'b0;

        // Power-up clear: exactly 16 cycles not ready, then all registers zero.
        expect_clear_window("reset_clear");
        sweep_zero("reset_zero");

        foreach (tbl[v]) begin
            t_wen = tbl[v].wen;
            t_wa[0] = tbl[v].wa0; t_wd[0] = tbl[v].wd0;
            t_wa[1] = tbl[v].wa1; t_wd[1] = tbl[v].wd1;
            t_iss = tbl[v].iss;   t_ia = tbl[v].ia;
            t_ra[0] = tbl[v].ra0; t_ra[1] = tbl[v].ra1; t_ra[2] = tbl[v].ra2;
            sample();
            chk("tbl_rd0", 0, v, act_rd[0][0], tbl[v].e0);
            chk("tbl_rd1", 0, v, act_rd[0][1], tbl[v].e1);
            chk("tbl_rd2", 0, v, act_rd[0][2], tbl[v].e2);
            chk("tbl_busy", 0, v, 16'(act_busy[0]), 16'(tbl[v].eb));
            advance();
        end

        // Fill every register and leave each one busy, then soft clear.
        for (int r = 0; r < 16; r += 2) begin
            t_wen = 2'b11;
            t_wa[0] = 4'(r);     t_wd[0] = 16'(16'hA500 + r);
            t_wa[1] = 4'(r + 1); t_wd[1] = 16'(16'h5A00 + r + 1);
            t_iss = 1'b1;        t_ia = 4'(r);
            t_ra[0] = 4'(r); t_ra[1] = 4'(r + 1); t_ra[2] = 4'd15;
            sample();
            advance();
        end
        idle();
        t_ra[0] = 4'd0; t_ra[1] = 4'd1; t_ra[2] = 4'd14;
        sample();
        chk("fill_rd", 0, 2, act_rd[0][2], 16'hA50E);
        chk("fill_busy", 0, 0, 16'(act_busy[0][0]), 16'h1);
        advance();

        t_clr = 1'b1;
        t_wen = 2'b11; t_wa[0] = 4'd3; t_wd[0] = 16'h1234; t_wa[1] = 4'd7; t_wd[1] = 16'h5678;
        t_iss = 1'b1;  t_ia = 4'd9;
        sample();
        advance();
        for (int c = 0; c < 16; c++) begin
            t_clr = 1'($urandom);
            t_wen = 2'($urandom); t_wa[0] = 4'($urandom); t_wa[1] = 4'($urandom);
            t_wd[0] = 16'($urandom) | 16'h1; t_wd[1] = 16'($urandom) | 16'h1;
            t_iss = 1'b1; t_ia = 4'($urandom);
            for (int k = 0; k < 3; k++) t_ra[k] = 4'($urandom);
            sample();
            chk("clr_ready", 0, c, 16'(act_ready[0]), 16'h0);
            for (int k = 0; k < 3; k++) begin
                chk("clr_rd", 0, k, act_rd[0][k], 16'h0);
                chk("clr_busy", 0, k, 16'(act_busy[0][k]), 16'h0);
            end
            advance();
        end
        idle();
        sample();
        chk("clr_done", 0, 0, 16'(act_ready[0]), 16'h1);
        advance();
        sweep_zero("after_clear");

        // Register 0: write + issue; hardwired instance must show zero, not busy.
        t_wen = 2'b01; t_wa[0] = 4'd0; t_wd[0] = 16'hFFFF;
        t_iss = 1'b1;  t_ia = 4'd0;
        t_ra = '0;
        sample();
        chk("r0_bypass_z", 1, 0, act_rd[1][0], 16'h0000);
        chk("r0_bypass", 0, 0, act_rd[0][0], 16'hFFFF);
        advance();
        idle();
        sample();
        chk("r0_data_z", 1, 0, act_rd[1][0], 16'h0000);
        chk("r0_busy_z", 1, 0, 16'(act_busy[1][0]), 16'h0);
        chk("r0_data", 0, 0, act_rd[0][0], 16'hFFFF);
        chk("r0_busy", 0, 0, 16'(act_busy[0][0]), 16'h1);
        advance();

        // Reset seven cycles into a soft clear restarts the full window.
        t_clr = 1'b1;
        sample();
        advance();
        t_clr = 1'b0;
        for (int c = 0; c < 7; c++) begin
            sample();
            advance();
        end
        t_rst = 1'b1;
        sample();
        advance();
        t_rst = 1'b0;
        expect_clear_window("rst_mid_clear");

        for (int n = 0; n < 500; n++) begin
            t_clr = ($urandom_range(0, 63) == 0);
            t_wen = t_clr ? 2'b00 : 2'($urandom);
            t_wa[0] = 4'($urandom); t_wa[1] = 4'($urandom);
            t_wd[0] = 16'($urandom); t_wd[1] = 16'($urandom);
            t_iss = 1'($urandom); t_ia = 4'($urandom);
            for (int k = 0; k < 3; k++)
                t_ra[k] = ($urandom_range(0, 3) == 0) ? t_wa[k % 2] : 4'($urandom);
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
